yarp_branch_sequencer: RTL and testbench

//  Sequences the YARP branch comparator for execute-stage control-flow instrs
//  (B-type, JAL, JALR) and turns the result into a PC redirect.

---
 rtl/yarp_branch_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_yarp_branch_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_branch_sequencer.sv
// yarp_branch_sequencer: drives the registered branch comparator for one
// control-flow instruction at a time. It resolves taken/target/misalignment,
// returns the result over a valid/ready response, pulses a flush on clean
// taken redirects and keeps saturating resolved/taken statistics.
module yarp_branch_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [XLEN-1:0]  req_pc_i,
  input  logic [XLEN-1:0]  req_imm_i,
  input  logic [XLEN-1:0]  req_opr_a_i,
  input  logic [XLEN-1:0]  req_opr_b_i,
  input  logic [2:0]       req_func3_i,
  input  logic [1:0]       req_kind_i,
  output logic [XLEN-1:0]  cmp_opr_a_o,
  output logic [XLEN-1:0]  cmp_opr_b_o,
  output logic             cmp_is_b_type_o,
  output logic [2:0]       cmp_func3_o,
  input  logic             cmp_taken_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_taken_o,
  output logic [XLEN-1:0]  rsp_target_o,
  output logic             rsp_misalign_o,
  output logic             flush_o,
  input  logic             stat_clr_i,
  output logic [CNT_W-1:0] stat_resolved_o,
  output logic [CNT_W-1:0] stat_taken_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_EVAL = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JAL    = 2'b01;
  localparam logic [1:0] KIND_JALR   = 2'b10;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_e            state_r;
  state_e            state_nxt_s;

  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   imm_r;
  logic [XLEN-1:0]   opr_a_r;
  logic [XLEN-1:0]   opr_b_r;
  logic [2:0]        func3_r;
  logic [1:0]        kind_r;
  logic              cmp_en_r;

  logic              rsp_valid_r;
  logic              rsp_taken_r;
  logic [XLEN-1:0]   rsp_target_r;
  logic              rsp_misalign_r;

  logic [CNT_W-1:0]  stat_resolved_r;
  logic [CNT_W-1:0]  stat_taken_r;

  logic              accept_s;
  logic              rsp_hs_s;
  logic              taken_s;
  logic [XLEN-1:0]   target_s;
  logic [XLEN-1:0]   jalr_sum_s;
  logic              misalign_s;

  assign accept_s = (state_r == ST_IDLE) & req_valid_i;
  assign rsp_hs_s = rsp_valid_r & rsp_ready_i;

  // Next-state sequencing of the four-phase request flow.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_nxt_s = ST_CMP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CMP:  state_nxt_s = ST_EVAL;
      ST_EVAL: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Resolve direction and next PC from the captured request and comparator.
  always_comb begin
    taken_s    = 1'b0;
    target_s   = pc_r + {{(XLEN-3){1'b0}}, 3'b100};
    jalr_sum_s = opr_a_r + imm_r;
    case (kind_r)
      KIND_BRANCH: taken_s = cmp_taken_i;
      KIND_JAL:    taken_s = 1'b1;
      KIND_JALR:   taken_s = 1'b1;
      default:     taken_s = 1'b0;
    endcase
    if (taken_s) begin
      if (kind_r == KIND_JALR) begin
        target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
      end else begin
        target_s = pc_r + imm_r;
      end
    end else begin
      target_s = pc_r + {{(XLEN-3){1'b0}}, 3'b100};
    end
    misalign_s = taken_s & target_s[1];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture request fields on acceptance; comparator enable lives for the CMP cycle only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_r     <= {XLEN{1'b0}};
      imm_r    <= {XLEN{1'b0}};
      opr_a_r  <= {XLEN{1'b0}};
      opr_b_r  <= {XLEN{1'b0}};
      func3_r  <= 3'b000;
      kind_r   <= 2'b00;
      cmp_en_r <= 1'b0;
    end else begin
      cmp_en_r <= accept_s & (req_kind_i == KIND_BRANCH);
      if (accept_s) begin
        pc_r    <= req_pc_i;
        imm_r   <= req_imm_i;
        opr_a_r <= req_opr_a_i;
        opr_b_r <= req_opr_b_i;
        func3_r <= req_func3_i;
        kind_r  <= req_kind_i;
      end
    end
  end

  // Response registers: loaded in EVAL, held until the consumer takes them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid_r    <= 1'b0;
      rsp_taken_r    <= 1'b0;
      rsp_target_r   <= {XLEN{1'b0}};
      rsp_misalign_r <= 1'b0;
    end else if (state_r == ST_EVAL) begin
      rsp_valid_r    <= 1'b1;
      rsp_taken_r    <= taken_s;
      rsp_target_r   <= target_s;
      rsp_misalign_r <= misalign_s;
    end else if (rsp_hs_s) begin
      rsp_valid_r    <= 1'b0;
    end
  end

  // Statistics: count handed-off responses; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_resolved_r <= {CNT_W{1'b0}};
      stat_taken_r    <= {CNT_W{1'b0}};
    end else if (stat_clr_i) begin
      stat_resolved_r <= {CNT_W{1'b0}};
      stat_taken_r    <= {CNT_W{1'b0}};
    end else if (rsp_hs_s) begin
      stat_resolved_r <= sat_inc(stat_resolved_r);
      if (rsp_taken_r) begin
        stat_taken_r <= sat_inc(stat_taken_r);
      end
    end
  end

  assign req_ready_o     = (state_r == ST_IDLE) & reset_n;
  assign cmp_opr_a_o     = opr_a_r;
  assign cmp_opr_b_o     = opr_b_r;
  assign cmp_func3_o     = func3_r;
  assign cmp_is_b_type_o = cmp_en_r;
  assign rsp_valid_o     = rsp_valid_r;
  assign rsp_taken_o     = rsp_taken_r;
  assign rsp_target_o    = rsp_target_r;
  assign rsp_misalign_o  = rsp_misalign_r;
  // The flush must coincide with the handshake, so it is decoded from held registers.
  assign flush_o         = reset_n & rsp_hs_s & rsp_taken_r & ~rsp_misalign_r;
  assign stat_resolved_o = stat_resolved_r;
  assign stat_taken_o    = stat_taken_r;

endmodule

// File: tb/tb_yarp_branch_sequencer.sv
// Scoreboard bench for yarp_branch_sequencer: directed scenarios followed by
// random traffic, checked against a transaction-level model of the sequencer.
module tb_yarp_branch_sequencer;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [XLEN-1:0]  req_pc_i;
  logic [XLEN-1:0]  req_imm_i;
  logic [XLEN-1:0]  req_opr_a_i;
  logic [XLEN-1:0]  req_opr_b_i;
  logic [2:0]       req_func3_i;
  logic [1:0]       req_kind_i;
  logic [XLEN-1:0]  cmp_opr_a_o;
  logic [XLEN-1:0]  cmp_opr_b_o;
  logic             cmp_is_b_type_o;
  logic [2:0]       cmp_func3_o;
  logic             cmp_taken_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_taken_o;
  logic [XLEN-1:0]  rsp_target_o;
  logic             rsp_misalign_o;
  logic             flush_o;
  logic             stat_clr_i;
  logic [CNT_W-1:0] stat_resolved_o;
  logic [CNT_W-1:0] stat_taken_o;

  yarp_branch_sequencer #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_pc_i(req_pc_i), .req_imm_i(req_imm_i),
    .req_opr_a_i(req_opr_a_i), .req_opr_b_i(req_opr_b_i),
    .req_func3_i(req_func3_i), .req_kind_i(req_kind_i),
    .cmp_opr_a_o(cmp_opr_a_o), .cmp_opr_b_o(cmp_opr_b_o),
    .cmp_is_b_type_o(cmp_is_b_type_o), .cmp_func3_o(cmp_func3_o),
    .cmp_taken_i(cmp_taken_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_taken_o(rsp_taken_o), .rsp_target_o(rsp_target_o),
    .rsp_misalign_o(rsp_misalign_o), .flush_o(flush_o),
    .stat_clr_i(stat_clr_i),
    .stat_resolved_o(stat_resolved_o), .stat_taken_o(stat_taken_o)
  );

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;      // 0 idle, 1..2 in flight, 3 response pending
  logic [1:0] cur_kind = 2'b00;
  int   m_res = 0;
  int   m_tak = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // RISC-V branch condition for a func3 code; undefined codes never take.
  function automatic logic br_cond(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Expected response of a request, straight from the redirect rules.
  function automatic exp_t ref_rsp(input logic [31:0] pc, input logic [31:0] imm,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f, input logic [1:0] kind);
    exp_t e;
    logic [31:0] s;
    e.taken = (kind == 2'b00) ? br_cond(a, b, f) : (kind != 2'b11);
    if (!e.taken)             e.target = pc + 32'd4;
    else if (kind == 2'b10) begin
      s = a + imm;
      e.target = s & 32'hFFFF_FFFE;
    end
    else                      e.target = pc + imm;
    e.mis = e.taken && e.target[1];
    return e;
  endfunction

  // Behavioural registered comparator; when not enabled it outputs noise.
  always @(posedge clk) begin
    if (cmp_is_b_type_o) cmp_taken_i <= br_cond(cmp_opr_a_o, cmp_opr_b_o, cmp_func3_o);
    else                 cmp_taken_i <= 1'($urandom_range(0, 1));
  end

  // Monitor/scoreboard: compare on the falling edge, then advance the model.
  always @(negedge clk) begin
    logic hs;
    logic exp_flush;
    hs = (phase == 3) && rsp_ready_i;
    chk("req_ready", {63'd0, req_ready_o}, {63'd0, reset_n && (phase == 0)});
    chk("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, phase == 3});
    chk("cmp_en", {63'd0, cmp_is_b_type_o}, {63'd0, (phase == 1) && (cur_kind == 2'b00)});
    if (rsp_valid_o) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        chk("rsp_taken", {63'd0, rsp_taken_o}, {63'd0, q[0].taken});
        chk("rsp_target", {32'd0, rsp_target_o}, {32'd0, q[0].target});
        chk("rsp_misalign", {63'd0, rsp_misalign_o}, {63'd0, q[0].mis});
      end
    end
    exp_flush = reset_n && hs && (q.size() > 0) && q[0].taken && !q[0].mis;
    chk("flush", {63'd0, flush_o}, {63'd0, exp_flush});
    chk("stat_resolved", 64'(stat_resolved_o), 64'(m_res));
    chk("stat_taken", 64'(stat_taken_o), 64'(m_tak));
    if (!reset_n) begin
      phase = 0; q.delete(); m_res = 0; m_tak = 0; cur_kind = 2'b00;
    end else begin
      if (stat_clr_i) begin
        m_res = 0; m_tak = 0;
      end else if (hs && q.size() > 0) begin
        if (m_res < CMAX) m_res++;
        if (q[0].taken && m_tak < CMAX) m_tak++;
      end
      case (phase)
        0: if (req_valid_i) begin
             q.push_back(ref_rsp(req_pc_i, req_imm_i, req_opr_a_i, req_opr_b_i, req_func3_i, req_kind_i));
             cur_kind = req_kind_i;
             phase = 1;
           end
        1: phase = 2;
        2: phase = 3;
        default: if (rsp_ready_i) begin
             if (q.size() > 0) void'(q.pop_front());
             phase = 0;
           end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted (bounded wait).
  task automatic issue(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] f, input logic [1:0] kind);
    bit done;
    done = 1'b0;
    req_pc_i = pc; req_imm_i = imm; req_opr_a_i = a; req_opr_b_i = b;
    req_func3_i = f; req_kind_i = kind; req_valid_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (req_ready_o) done = 1'b1;
      tick();
    end
    req_valid_i = 1'b0;
    if (!done) chk("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b1; stat_clr_i = 1'b0;
    req_pc_i = '0; req_imm_i = '0; req_opr_a_i = '0; req_opr_b_i = '0;
    req_func3_i = 3'b000; req_kind_i = 2'b00;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // BEQ taken, BLTU not taken, JALR misaligned, JAL backwards.
    issue(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 2'b00);           drain(5);
    issue(32'h100, 32'h40, 32'hFFFF_FFFF, 32'd1, 3'b110, 2'b00);   drain(5);
    issue(32'h0, 32'h1, 32'h1001, 32'd0, 3'b000, 2'b10);           drain(5);
    issue(32'h200, 32'hFFFF_FFF8, 32'd0, 32'd0, 3'b000, 2'b01);    drain(5);
    issue(32'h300, 32'h10, 32'd0, 32'd0, 3'b000, 2'b11);           drain(5);

    // Back-pressure: consumer stalls while another request is held pending.
    rsp_ready_i = 1'b0;
    issue(32'h400, 32'h8, 32'd3, 32'd4, 3'b100, 2'b00);
    req_pc_i = 32'h500; req_kind_i = 2'b01; req_imm_i = 32'h4; req_valid_i = 1'b1;
    drain(7);
    rsp_ready_i = 1'b1;
    drain(2);
    req_valid_i = 1'b0;
    drain(6);

    // Reset arrives while the request is in EVAL; it must never respond.
    issue(32'h600, 32'h10, 32'd1, 32'd1, 3'b000, 2'b00);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drain(4);

    // Counter saturation, then a clear landing on a handshake cycle.
    for (int i = 0; i < 5; i++) begin
      issue(32'h700, 32'h10, 32'd0, 32'd0, 3'b000, 2'b01);
      drain(4);
    end
    issue(32'h800, 32'h10, 32'd0, 32'd0, 3'b000, 2'b01);
    tick(); tick();
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    drain(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid_i = ($urandom_range(0, 99) < 60);
      req_kind_i  = 2'($urandom_range(0, 3));
      req_func3_i = 3'($urandom_range(0, 7));
      req_pc_i    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      req_imm_i   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(12'($urandom)));
      req_opr_a_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      req_opr_b_i = ($urandom_range(0, 2) == 0) ? req_opr_a_i : $urandom;
      rsp_ready_i = ($urandom_range(0, 99) < 55);
      stat_clr_i  = ($urandom_range(0, 99) < 3);
      reset_n     = ($urandom_range(0, 199) != 0);
      tick();
    end

    req_valid_i = 1'b0; rsp_ready_i = 1'b1; stat_clr_i = 1'b0; reset_n = 1'b1;
    drain(10);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
